// File: rtl/dac_arb_pkg.sv
// Shared FSM state type, default parameters and width helpers for dac_write_arbiter.
package dac_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StGap,
        StLdac
    } state_t;

    localparam int unsigned DefNumReq  = 4;
    localparam int unsigned DefDataW   = 16;
    localparam int unsigned DefGapCyc  = 2;
    localparam int unsigned DefTimeout = 64;
    localparam int unsigned DefLdacCyc = 2;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter
    import dac_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/dac_write_arbiter.sv
// Shares one DAC SPI serializer between NUM_REQ shadow-register requesters, round-robin.
// Optional shared LDAC strobe after a drained burst is enabled by defining DAC_LDAC_EN.
module dac_write_arbiter
    import dac_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DefNumReq,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned GAP_CYC  = DefGapCyc,
    parameter int unsigned TIMEOUT  = DefTimeout,
    parameter int unsigned LDAC_CYC = DefLdacCyc
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         wr_en,
    input  logic [NUM_REQ*DATA_W-1:0]  wr_data,
    output logic [NUM_REQ-1:0]         pending,
    output logic                       busy,
    output logic                       err_tmo,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    output logic [idx_w(NUM_REQ)-1:0]  tx_sel,
    input  logic                       tx_done,
    output logic                       ldac_n
);

    localparam int unsigned IDX_W   = idx_w(NUM_REQ);
    localparam int unsigned CNT_MAX = max3(TIMEOUT, GAP_CYC, LDAC_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shadow_q [NUM_REQ];
    logic [DATA_W-1:0]   shadow_d [NUM_REQ];
    logic [NUM_REQ-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                err_q, err_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [IDX_W-1:0]    tx_sel_q, tx_sel_d;
`ifdef DAC_LDAC_EN
    logic                flush_q, flush_d;
    logic                ldac_n_q, ldac_n_d;
`endif

    logic [NUM_REQ-1:0]  gnt;
    logic [IDX_W-1:0]    win_idx;
    logic                any_pend;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i (pending_q),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (any_pend)
    );

    assign cnt_inc = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        err_d      = err_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tx_sel_d   = tx_sel_q;
`ifdef DAC_LDAC_EN
        flush_d    = flush_q;
        ldac_n_d   = 1'b1;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_pend) begin
                    tx_data_d  = shadow_q[win_idx];
                    tx_sel_d   = win_idx;
                    pending_d  = pending_q & ~gnt;
                    ptr_d      = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (tx_done) begin
                    cnt_d   = '0;
                    state_d = StGap;
`ifdef DAC_LDAC_EN
                    flush_d = 1'b1;
`endif
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StGap;
`ifdef DAC_LDAC_EN
                    flush_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StGap: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
`ifdef DAC_LDAC_EN
                    // Only strobe LDAC once the whole burst has drained.
                    if (!any_pend && flush_q) begin
                        cnt_d    = '0;
                        ldac_n_d = 1'b0;
                        state_d  = StLdac;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StLdac: begin
`ifdef DAC_LDAC_EN
                if (cnt_q == CNT_W'(LDAC_CYC - 1)) begin
                    flush_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d    = cnt_inc;
                    ldac_n_d = 1'b0;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase

        // Writes land after the grant so a same-cycle write re-arms pending with the new word.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_en[i]) begin
                shadow_d[i]  = wr_data[i*DATA_W +: DATA_W];
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            shadow_q   <= '{default: '0};
            pending_q  <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            tx_sel_q   <= '0;
`ifdef DAC_LDAC_EN
            flush_q    <= 1'b0;
            ldac_n_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tx_sel_q   <= tx_sel_d;
`ifdef DAC_LDAC_EN
            flush_q    <= flush_d;
            ldac_n_q   <= ldac_n_d;
`endif
        end
    end

    assign pending  = pending_q;
    assign busy     = (state_q != StIdle);
    assign err_tmo  = err_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign tx_sel   = tx_sel_q;
`ifdef DAC_LDAC_EN
    assign ldac_n   = ldac_n_q;
`else
    assign ldac_n   = 1'b1;
`endif

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Bench for dac_write_arbiter: per-cycle reference model plus directed literal checks.
module tb_dac_write_arbiter;

    localparam int N        = 4;
    localparam int W        = 16;
    localparam int GAP      = 2;
    localparam int TMO      = 64;
    localparam int LCYC     = 2;
    localparam int RESP_LAT = 3;
`ifdef DAC_LDAC_EN
    localparam bit LDAC_EN = 1'b1;
`else
    localparam bit LDAC_EN = 1'b0;
`endif

    localparam int P_IDLE = 0, P_START = 1, P_WAIT = 2, P_GAP = 3, P_LDAC = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   wr_en = '0;
    logic [N*W-1:0] wr_data = '0;
    logic [N-1:0]   pending;
    logic           busy, err_tmo, tx_start, ldac_n;
    logic [W-1:0]   tx_data;
    logic [1:0]     tx_sel;
    logic           tx_done = 1'b0;
    bit             resp_en = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    dac_write_arbiter #(
        .NUM_REQ  (N),
        .DATA_W   (W),
        .GAP_CYC  (GAP),
        .TIMEOUT  (TMO),
        .LDAC_CYC (LCYC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .pending  (pending),
        .busy     (busy),
        .err_tmo  (err_tmo),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_sel   (tx_sel),
        .tx_done  (tx_done),
        .ldac_n   (ldac_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_shadow [N];
    logic [N-1:0] m_pend;
    int           m_ptr, m_ph, m_rem, m_sel;
    bit           m_err, m_flush, m_start, m_ldac_n;
    logic [W-1:0] m_data;

    task automatic model_step();
        int  w;
        bit  anyp;
        if (!reset_n) begin
            for (int i = 0; i < N; i++) m_shadow[i] = '0;
            m_pend = '0; m_ptr = 0; m_ph = P_IDLE; m_rem = 0; m_sel = 0;
            m_err = 0; m_flush = 0; m_start = 0; m_ldac_n = 1; m_data = '0;
            return;
        end
        anyp = (m_pend != '0);
        case (m_ph)
            P_IDLE: if (anyp) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_data = m_shadow[w];
                m_sel = w;
                m_pend[w] = 1'b0;
                m_ptr = (w + 1) % N;
                m_start = 1;
                m_ph = P_START;
            end
            P_START: begin
                m_start = 0; m_ph = P_WAIT; m_rem = TMO;
            end
            P_WAIT: begin
                m_rem--;
                if (tx_done || m_rem == 0) begin
                    if (!tx_done) m_err = 1;
                    m_flush = 1; m_ph = P_GAP; m_rem = GAP;
                end
            end
            P_GAP: begin
                m_rem--;
                if (m_rem == 0) begin
                    if (LDAC_EN && !anyp && m_flush) begin
                        m_ph = P_LDAC; m_rem = LCYC; m_ldac_n = 0;
                    end else begin
                        m_ph = P_IDLE;
                    end
                end
            end
            default: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ldac_n = 1; m_flush = 0; m_ph = P_IDLE;
                end
            end
        endcase
        for (int i = 0; i < N; i++)
            if (wr_en[i]) begin
                m_shadow[i] = wr_data[i*W +: W];
                m_pend[i] = 1'b1;
            end
    endtask

    always @(posedge clk) begin
        model_step();
        #2;
        check("pending",  32'(pending),  32'(m_pend));
        check("busy",     32'(busy),     32'(m_ph != P_IDLE));
        check("err_tmo",  32'(err_tmo),  32'(m_err));
        check("tx_start", 32'(tx_start), 32'(m_start));
        check("tx_data",  32'(tx_data),  32'(m_data));
        check("tx_sel",   32'(tx_sel),   32'(m_sel));
        check("ldac_n",   32'(ldac_n),   32'(m_ldac_n));
    end

    // ---------------- transfer monitor and serializer stand-in ----------------
    typedef struct {
        int           sel;
        logic [W-1:0] data;
    } xfer_t;
    xfer_t starts[$];
    int    ldac_pulses, ldac_low, ldac_at, done_cnt;
    bit    ldac_prev = 1'b1;

    always @(negedge clk) begin
        if (!reset_n) begin
            starts.delete();
            ldac_pulses = 0; ldac_low = 0; ldac_at = 0; done_cnt = 0;
            ldac_prev = 1'b1; tx_done = 1'b0;
        end else begin
            if (tx_start) starts.push_back('{int'(tx_sel), tx_data});
            if (!ldac_n) ldac_low++;
            if (!ldac_n && ldac_prev) begin
                ldac_pulses++;
                ldac_at = starts.size();
            end
            ldac_prev = ldac_n;
            tx_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) tx_done = 1'b1;
            end else if (tx_start && resp_en) begin
                done_cnt = RESP_LAT;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        wr_en = '0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic wr1(input int idx, input logic [W-1:0] v);
        @(negedge clk);
        wr_en = '0;
        wr_en[idx] = 1'b1;
        wr_data[idx*W +: W] = v;
        @(negedge clk);
        wr_en = '0;
    endtask

    task automatic wait_starts(input string name, input int n, input int budget);
        int b;
        b = budget;
        while (starts.size() < n && b > 0) begin
            @(negedge clk);
            #1;
            b--;
        end
        check(name, 32'(starts.size() >= n), 32'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // 1: reset held while wr_en toggles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_en = i[0] ? '1 : '0;
            wr_data = {$urandom, $urandom};
        end
        tick(1);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_tx", 32'({tx_start, tx_sel, tx_data}), 32'h0);
        check("rst_err_ldac", 32'({err_tmo, ldac_n}), 32'h1);
        wr_en = '0;
        reset_n = 1'b1;
        tick(5);
        check("rst_no_start", 32'(starts.size()), 32'h0);

        // 2: single write, 2-cycle latency, return to idle after the gap
        @(negedge clk);
        wr_en = 4'b0100;
        wr_data[2*W +: W] = 16'h1A2B;
        @(negedge clk);
        wr_en = '0;
        check("single_pend", 32'(pending), 32'h4);
        @(negedge clk);
        check("single_start", 32'(tx_start), 32'h1);
        check("single_data", 32'(tx_data), 32'h1A2B);
        check("single_sel", 32'(tx_sel), 32'h2);
        check("single_clear", 32'(pending), 32'h0);
        tick(5);
        check("single_gap_busy", 32'(busy), 32'h1);
        tick(1);
        check("single_idle", 32'(busy), 32'(LDAC_EN));
        tick(10);

        // 3a: all four at once from ptr 0
        do_reset();
        @(negedge clk);
        wr_en = 4'b1111;
        wr_data = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        @(negedge clk);
        wr_en = '0;
        wait_starts("rr4_done", 4, 100);
        for (int i = 0; i < 4; i++) begin
            check("rr4_sel", 32'(starts[i].sel), 32'(i));
            check("rr4_data", 32'(starts[i].data), 32'(16'h0100 + i));
        end
        // 3b: pending 0 and 3 with ptr 1 -> 3 then 0
        do_reset();
        wr1(0, 16'h00A0);
        wait_starts("rr2_first", 1, 20);
        @(negedge clk);
        wr_en = 4'b1001;
        wr_data[0 +: W] = 16'h00B0;
        wr_data[3*W +: W] = 16'h00B3;
        @(negedge clk);
        wr_en = '0;
        wait_starts("rr2_done", 3, 60);
        check("rr2_sel1", 32'(starts[1].sel), 32'h3);
        check("rr2_data1", 32'(starts[1].data), 32'h00B3);
        check("rr2_sel2", 32'(starts[2].sel), 32'h0);
        check("rr2_data2", 32'(starts[2].data), 32'h00B0);

        // 4a: coalesce two writes to req1 before its grant
        do_reset();
        wr1(0, 16'h0AAA);
        wait_starts("coal_first", 1, 20);
        wr1(1, 16'h0001);
        wr1(1, 16'h0002);
        tick(30);
        check("coal_count", 32'(starts.size()), 32'h2);
        check("coal_sel", 32'(starts[1].sel), 32'h1);
        check("coal_data", 32'(starts[1].data), 32'h0002);

        // 4b: write in the grant cycle -> old value, then new
        do_reset();
        @(negedge clk);
        wr_en = 4'b0010;
        wr_data[W +: W] = 16'hAAAA;
        @(negedge clk);
        wr_data[W +: W] = 16'hBBBB;
        @(negedge clk);
        wr_en = '0;
        check("coll_repend", 32'(pending), 32'h2);
        check("coll_first", 32'(tx_data), 32'hAAAA);
        wait_starts("coll_done", 2, 40);
        check("coll_second", 32'(starts[1].data), 32'hBBBB);
        check("coll_sel", 32'(starts[1].sel), 32'h1);

        // 5: timeout, next pending still served, err sticky
        do_reset();
        resp_en = 1'b0;
        wr1(2, 16'h5555);
        @(negedge clk);
        check("tmo_start", 32'(tx_start), 32'h1);
        wr1(3, 16'h6666);
        tick(62);
        check("tmo_before", 32'(err_tmo), 32'h0);
        tick(1);
        check("tmo_set", 32'(err_tmo), 32'h1);
        resp_en = 1'b1;
        wait_starts("tmo_next", 2, 20);
        check("tmo_next_sel", 32'(starts[1].sel), 32'h3);
        check("tmo_next_data", 32'(starts[1].data), 32'h6666);
        tick(20);
        check("tmo_sticky", 32'(err_tmo), 32'h1);

        // 6: three-write burst -> one LDAC pulse after the last gap (none without the feature)
        do_reset();
        @(negedge clk);
        wr_en = 4'b1110;
        wr_data = {16'h0333, 16'h0222, 16'h0111, 16'h0000};
        @(negedge clk);
        wr_en = '0;
        wait_starts("ldac_burst", 3, 60);
        tick(20);
        check("ldac_pulses", 32'(ldac_pulses), 32'(LDAC_EN ? 1 : 0));
        check("ldac_width", 32'(ldac_low), 32'(LDAC_EN ? LCYC : 0));
        check("ldac_after3", 32'(ldac_at), 32'(LDAC_EN ? 3 : 0));
        check("ldac_idle", 32'({busy, ldac_n}), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
